// File: rtl/readout_scheduler_if.sv
// Row-buffer control and downstream beat handshake between the readout scheduler
// and the output buffer / link.
interface readout_scheduler_if #(
    parameter int unsigned ROW_BITS  = 2,
    parameter int unsigned BEAT_BITS = 2
);
    logic [ROW_BITS-1:0]  row_sel;
    logic                 buf_load;
    logic                 buf_shift;
    logic                 out_valid;
    logic                 out_ready;
    logic [BEAT_BITS-1:0] beat_idx;
    logic                 out_last;

    modport master (
        output row_sel, buf_load, buf_shift, out_valid, beat_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  row_sel, buf_load, buf_shift, out_valid, beat_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/readout_scheduler.sv
// Frame readout sequencer: per row, load the output buffer then shift out beats.
// Optional inter-row idle gap enabled by defining READOUT_ROW_GAP_EN.
module readout_scheduler #(
    parameter int unsigned PIXEL_ARRAY_HEIGHT = 4,
    parameter int unsigned PIXEL_ARRAY_WIDTH  = 8,
    parameter int unsigned OUTPUT_BUS_WIDTH   = 2,
    parameter int unsigned ROW_GAP_CYCLES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    input  logic abort,
    output logic busy,
    output logic frame_done,
    output logic frame_overrun,
    readout_scheduler_if.master link
);

    localparam int unsigned BEATS     = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int unsigned ROW_BITS  = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int unsigned BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ROW_BITS-1:0]  ROW_LAST  = ROW_BITS'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(BEATS - 1);

    // Elaboration-time parameter sanity
    if (PIXEL_ARRAY_HEIGHT < 1) begin : g_bad_height
        $error("PIXEL_ARRAY_HEIGHT must be >= 1");
    end
    if (OUTPUT_BUS_WIDTH < 1 || PIXEL_ARRAY_WIDTH < OUTPUT_BUS_WIDTH ||
        (PIXEL_ARRAY_WIDTH % OUTPUT_BUS_WIDTH) != 0) begin : g_bad_width
        $error("PIXEL_ARRAY_WIDTH must be a non-zero multiple of OUTPUT_BUS_WIDTH");
    end
    if (ROW_GAP_CYCLES >= 65536) begin : g_bad_gap
        $error("ROW_GAP_CYCLES out of range");
    end

`ifdef READOUT_ROW_GAP_EN
    localparam int unsigned GAP_BITS = (ROW_GAP_CYCLES > 1) ? $clog2(ROW_GAP_CYCLES) : 1;
    localparam logic [GAP_BITS-1:0] GAP_LAST =
        GAP_BITS'((ROW_GAP_CYCLES > 0) ? ROW_GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    logic [GAP_BITS-1:0] gap_cnt_q, gap_cnt_d;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [ROW_BITS-1:0]  row_cnt_q, row_cnt_d;
    logic [BEAT_BITS-1:0] beat_cnt_q, beat_cnt_d;

    logic [ROW_BITS-1:0]  row_sel_q, row_sel_d;
    logic [BEAT_BITS-1:0] beat_idx_q, beat_idx_d;
    logic buf_load_q, buf_load_d;
    logic out_valid_q, out_valid_d;
    logic out_last_q, out_last_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;
    logic frame_overrun_q, frame_overrun_d;
    logic buf_shift_c;

    // Next-state, counters and next registered outputs
    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        beat_cnt_d = beat_cnt_q;
`ifdef READOUT_ROW_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (frame_start && !abort) begin
                    state_d    = S_LOAD;
                    row_cnt_d  = '0;
                    beat_cnt_d = '0;
                end
            end
            S_LOAD: begin
                state_d    = S_SHIFT;
                beat_cnt_d = '0;
            end
            S_SHIFT: begin
                if (link.out_ready) begin
                    if (beat_cnt_q == BEAT_LAST) begin
                        beat_cnt_d = '0;
                        if (row_cnt_q == ROW_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            row_cnt_d = row_cnt_q + ROW_BITS'(1);
`ifdef READOUT_ROW_GAP_EN
                            gap_cnt_d = '0;
                            state_d   = (ROW_GAP_CYCLES == 0) ? S_LOAD : S_GAP;
`else
                            state_d   = S_LOAD;
`endif
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_BITS'(1);
                    end
                end
            end
`ifdef READOUT_ROW_GAP_EN
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_BITS'(1);
                end
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort cancels any in-flight frame, winning over a same-cycle handshake
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            row_cnt_d  = '0;
            beat_cnt_d = '0;
`ifdef READOUT_ROW_GAP_EN
            gap_cnt_d  = '0;
`endif
        end

        busy_d          = (state_d != S_IDLE);
        buf_load_d      = (state_d == S_LOAD);
        out_valid_d     = (state_d == S_SHIFT);
        row_sel_d       = (state_d == S_LOAD || state_d == S_SHIFT) ? row_cnt_d : '0;
        beat_idx_d      = (state_d == S_SHIFT) ? beat_cnt_d : '0;
        out_last_d      = (state_d == S_SHIFT) && (row_cnt_d == ROW_LAST) &&
                          (beat_cnt_d == BEAT_LAST);
        frame_done_d    = (state_d == S_DONE);
        frame_overrun_d = frame_start && !abort && (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            row_cnt_q       <= '0;
            beat_cnt_q      <= '0;
            row_sel_q       <= '0;
            beat_idx_q      <= '0;
            buf_load_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_overrun_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_cnt_q       <= row_cnt_d;
            beat_cnt_q      <= beat_cnt_d;
            row_sel_q       <= row_sel_d;
            beat_idx_q      <= beat_idx_d;
            buf_load_q      <= buf_load_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            frame_overrun_q <= frame_overrun_d;
        end
    end

`ifdef READOUT_ROW_GAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    // Shift strobe coincides with the accepted beat; an abort suppresses it
    assign buf_shift_c = out_valid_q && link.out_ready && !abort;

    assign link.row_sel   = row_sel_q;
    assign link.buf_load  = buf_load_q;
    assign link.buf_shift = buf_shift_c;
    assign link.out_valid = out_valid_q;
    assign link.beat_idx  = beat_idx_q;
    assign link.out_last  = out_last_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign frame_overrun  = frame_overrun_q;

endmodule

// File: tb/tb_readout_scheduler.sv
// Bench for readout_scheduler: a frame-timeline model is built from each stimulus
// table and compared against the DUT every cycle, plus hand-computed pins.
module tb_readout_scheduler;

    localparam int H     = 4;
    localparam int W     = 8;
    localparam int B     = 2;
    localparam int GAP   = 2;
    localparam int BEATS = W / B;
    localparam int RB    = (H > 1) ? $clog2(H) : 1;
    localparam int BB    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NC    = 96;

`ifdef READOUT_ROW_GAP_EN
    localparam int GAPC     = GAP;
    localparam int DONE1    = 27;
    localparam int LAST1    = 26;
    localparam int STALL    = 11;
    localparam int DONE2    = 30;
    localparam int ABORT_AT = 17;
    localparam int DONE4    = 57;
`else
    localparam int GAPC     = 0;
    localparam int DONE1    = 21;
    localparam int LAST1    = 20;
    localparam int STALL    = 9;
    localparam int DONE2    = 24;
    localparam int ABORT_AT = 13;
    localparam int DONE4    = 51;
`endif

    logic clk;
    logic reset;
    logic frame_start;
    logic abort;
    logic busy;
    logic frame_done;
    logic frame_overrun;

    readout_scheduler_if #(.ROW_BITS(RB), .BEAT_BITS(BB)) link ();

    readout_scheduler #(
        .PIXEL_ARRAY_HEIGHT(H),
        .PIXEL_ARRAY_WIDTH (W),
        .OUTPUT_BUS_WIDTH  (B),
        .ROW_GAP_CYCLES    (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .abort        (abort),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_overrun(frame_overrun),
        .link         (link.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit fs  [NC+2];
    bit ab  [NC+2];
    bit rdy [NC+2];

    bit e_busy [NC+2];
    bit e_load [NC+2];
    bit e_valid[NC+2];
    bit e_shift[NC+2];
    bit e_last [NC+2];
    bit e_done [NC+2];
    bit e_ovr  [NC+2];
    int e_row  [NC+2];
    int e_beat [NC+2];

    int checks;
    int failures;
    int n_shift, n_load, n_done, n_ovr, last_done, last_last, last_ovr;

    task automatic check(input string name, input int c, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, c, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NC + 2; i++) begin
            fs[i]  = 1'b0;
            ab[i]  = 1'b0;
            rdy[i] = 1'b1;
        end
    endtask

    // Lay out each accepted frame as a timeline: load, beats (stretched by stalls), done
    task automatic build_model();
        int c;
        int t;
        bit cut;
        bit acc;
        for (int i = 0; i < NC + 2; i++) begin
            e_busy[i] = 0; e_load[i] = 0; e_valid[i] = 0; e_shift[i] = 0;
            e_last[i] = 0; e_done[i] = 0; e_ovr[i] = 0; e_row[i] = 0; e_beat[i] = 0;
        end
        c = 0;
        while (c < NC) begin
            if (!fs[c] || ab[c]) begin
                c++;
                continue;
            end
            t   = c + 1;
            cut = 0;
            for (int r = 0; r < H && !cut; r++) begin
                for (int g = 0; r > 0 && g < GAPC && !cut; g++) begin
                    e_busy[t] = 1;
                    cut = ab[t] || (t >= NC - 1);
                    t++;
                end
                if (!cut) begin
                    e_busy[t] = 1; e_load[t] = 1; e_row[t] = r;
                    cut = ab[t] || (t >= NC - 1);
                    t++;
                end
                for (int b = 0; b < BEATS && !cut; b++) begin
                    acc = 0;
                    while (!acc && !cut) begin
                        e_busy[t] = 1; e_valid[t] = 1; e_row[t] = r; e_beat[t] = b;
                        e_last[t] = (r == H - 1) && (b == BEATS - 1);
                        acc = rdy[t] && !ab[t];
                        e_shift[t] = acc;
                        cut = ab[t] || (t >= NC - 1);
                        t++;
                    end
                end
            end
            if (!cut) begin
                e_busy[t] = 1; e_done[t] = 1;
                t++;
            end
            for (int u = c + 1; u < t && u < NC; u++) begin
                if (fs[u] && !ab[u]) e_ovr[u+1] = 1;
            end
            c = t;
        end
    endtask

    task automatic compare_cycle(input int c);
        check("busy",          c, int'(busy),           int'(e_busy[c]));
        check("buf_load",      c, int'(link.buf_load),  int'(e_load[c]));
        check("buf_shift",     c, int'(link.buf_shift), int'(e_shift[c]));
        check("out_valid",     c, int'(link.out_valid), int'(e_valid[c]));
        check("row_sel",       c, int'(link.row_sel),   e_row[c]);
        check("beat_idx",      c, int'(link.beat_idx),  e_beat[c]);
        check("out_last",      c, int'(link.out_last),  int'(e_last[c]));
        check("frame_done",    c, int'(frame_done),     int'(e_done[c]));
        check("frame_overrun", c, int'(frame_overrun),  int'(e_ovr[c]));
        if (link.buf_shift) n_shift++;
        if (link.buf_load)  n_load++;
        if (frame_done)    begin n_done++; last_done = c; end
        if (link.out_last) last_last = c;
        if (frame_overrun) begin n_ovr++; last_ovr = c; end
    endtask

    task automatic check_all_zero(input string name, input int c);
        check({name, "_busy"},  c, int'(busy),           0);
        check({name, "_load"},  c, int'(link.buf_load),  0);
        check({name, "_shift"}, c, int'(link.buf_shift), 0);
        check({name, "_valid"}, c, int'(link.out_valid), 0);
        check({name, "_row"},   c, int'(link.row_sel),   0);
        check({name, "_beat"},  c, int'(link.beat_idx),  0);
        check({name, "_last"},  c, int'(link.out_last),  0);
        check({name, "_done"},  c, int'(frame_done),     0);
        check({name, "_ovr"},   c, int'(frame_overrun),  0);
    endtask

    task automatic apply_reset();
        frame_start    = 1'b0;
        abort          = 1'b0;
        link.out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset", -1);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_scenario();
        build_model();
        n_shift = 0; n_load = 0; n_done = 0; n_ovr = 0;
        last_done = -1; last_last = -1; last_ovr = -1;
        apply_reset();
        for (int c = 0; c < NC; c++) begin
            @(posedge clk);
            #1;
            frame_start    = fs[c];
            abort          = ab[c];
            link.out_ready = rdy[c];
            @(negedge clk);
            compare_cycle(c);
        end
        frame_start    = 1'b0;
        abort          = 1'b0;
        link.out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        frame_start    = 1'b0;
        abort          = 1'b0;
        link.out_ready = 1'b1;

        // Plain frame, downstream always ready
        clear_stim();
        fs[0] = 1;
        run_scenario();
        check("s1_done_at",  -1, last_done, DONE1);
        check("s1_done_cnt", -1, n_done,    1);
        check("s1_last_at",  -1, last_last, LAST1);
        check("s1_shifts",   -1, n_shift,   16);
        check("s1_loads",    -1, n_load,    4);

        // Three-cycle back-pressure at row 1 beat 2
        clear_stim();
        fs[0] = 1;
        for (int i = 0; i < 3; i++) rdy[STALL+i] = 0;
        run_scenario();
        check("s2_done_at", -1, last_done, DONE2);
        check("s2_shifts",  -1, n_shift,   16);

        // Second frame_start while busy is ignored but flagged
        clear_stim();
        fs[0] = 1;
        fs[8] = 1;
        run_scenario();
        check("s3_ovr_cnt",  -1, n_ovr,     1);
        check("s3_ovr_at",   -1, last_ovr,  9);
        check("s3_done_at",  -1, last_done, DONE1);
        check("s3_done_cnt", -1, n_done,    1);

        // Abort at row 2 beat 1, restart, then abort-only and abort+start in IDLE
        clear_stim();
        fs[0]        = 1;
        ab[ABORT_AT] = 1;
        fs[30]       = 1;
        fs[62]       = 1;
        ab[62]       = 1;
        ab[65]       = 1;
        run_scenario();
        check("s4_loads",    -1, n_load,    7);
        check("s4_shifts",   -1, n_shift,   25);
        check("s4_done_cnt", -1, n_done,    1);
        check("s4_done_at",  -1, last_done, DONE4);
        check("s4_ovr_cnt",  -1, n_ovr,     0);

        // Irregular ready pattern across two back-to-back frames
        clear_stim();
        fs[0]  = 1;
        fs[40] = 1;
        for (int i = 0; i < NC; i++) rdy[i] = (i % 3) != 0;
        run_scenario();
        check("s6_done_cnt", -1, n_done,  2);
        check("s6_shifts",   -1, n_shift, 32);

        // Asynchronous reset between edges in the middle of SHIFT
        apply_reset();
        @(posedge clk); #1; frame_start = 1'b1;
        @(posedge clk); #1; frame_start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("s5_pre_valid", 3, int'(link.out_valid), 1);
        check("s5_pre_beat",  3, int'(link.beat_idx),  1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("s5_async", 3);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s5_idle_busy",  i, int'(busy),           0);
            check("s5_idle_valid", i, int'(link.out_valid), 0);
            check("s5_idle_load",  i, int'(link.buf_load),  0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
